// File: rtl/surf_dout_event_emitter.sv
// Emits one fixed-length dout event per queued trigger: a 4-byte header, then NUM_CH*CH_BYTES data bytes.
// Latency: each byte is registered and appears on the cycle after its pace tick. Events are separated by at least one empty slot.
// Backpressure: none on the output. SURF_DOUT_TEST_PATTERN_EN replaces the data bytes with the low byte of the byte index.
module surf_dout_event_emitter #(
    parameter int NUM_CH      = 8,
    parameter int CH_BYTES    = 1536,
    parameter int BYTE_PERIOD = 4,
    parameter int TRIG_DEPTH  = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        trig_i,
    input  logic [14:0] trig_time_i,
    input  logic [7:0]  s_data_tdata,
    input  logic        s_data_tvalid,
    output logic        s_data_tready,
    output logic [7:0]  m_dout_tdata,
    output logic        m_dout_tvalid,
    output logic        busy_o,
    output logic        trig_overflow_o,
    output logic        underflow_o
);
    localparam int NUM_BYTES = 4 + NUM_CH * CH_BYTES;
    localparam int BCW       = $clog2(NUM_BYTES);
    localparam int PCW       = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;
    localparam int QAW       = (TRIG_DEPTH > 1) ? $clog2(TRIG_DEPTH) : 1;

    // GAP is the mandatory empty slot after an event; it is still "busy" so
    // busy_o stays up across back-to-back events.
    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

    state_t           state_q, state_d;
    logic [PCW-1:0]   pace_q;
    logic             tick;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [14:0]      cur_time_q, cur_ev_q, evcnt_q;
    logic [7:0]       dout_dat_q, emit_dat;
    logic             dout_vld_q, emit, emit_b0, unf_set;
    logic             ovf_q, unf_q;

    logic [14:0]      q_mem [TRIG_DEPTH];
    logic [QAW-1:0]   q_wr, q_rd;
    logic [QAW:0]     q_cnt;
    logic             q_empty, q_full, q_push, q_pop;
    logic [14:0]      q_head;

    assign tick    = (pace_q == PCW'(BYTE_PERIOD - 1));
    assign q_empty = (q_cnt == '0);
    assign q_full  = (q_cnt == (QAW+1)'(TRIG_DEPTH));
    assign q_push  = trig_i && !q_full;
    assign q_head  = q_mem[q_rd];

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        q_pop      = 1'b0;
        emit       = 1'b0;
        emit_b0    = 1'b0;
        emit_dat   = 8'h00;
        unf_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && !q_empty) begin
                    q_pop      = 1'b1;
                    emit       = 1'b1;
                    emit_b0    = 1'b1;
                    emit_dat   = {1'b1, q_head[14:8]};
                    byte_cnt_d = BCW'(1);
                    state_d    = HDR;
                end
            end
            GAP: begin
                // Popping here arms the next event so B0 goes out on the following tick.
                if (tick) begin
                    if (!q_empty) begin
                        q_pop      = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = HDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HDR: begin
                if (tick) begin
                    emit = 1'b1;
                    case (byte_cnt_q[1:0])
                        2'd0: begin
                            emit_b0  = 1'b1;
                            emit_dat = {1'b1, cur_time_q[14:8]};
                        end
                        2'd1:    emit_dat = cur_time_q[7:0];
                        2'd2:    emit_dat = {1'b0, cur_ev_q[14:8]};
                        default: emit_dat = cur_ev_q[7:0];
                    endcase
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_q[1:0] == 2'd3) state_d = DATA;
                end
            end
            default: begin
                if (tick) begin
                    emit = 1'b1;
`ifdef SURF_DOUT_TEST_PATTERN_EN
                    emit_dat = 8'(byte_cnt_q);
`else
                    emit_dat = s_data_tvalid ? s_data_tdata : 8'h00;
                    unf_set  = !s_data_tvalid;
`endif
                    if (byte_cnt_q == BCW'(NUM_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = GAP;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            pace_q     <= '0;
            byte_cnt_q <= '0;
            q_wr       <= '0;
            q_rd       <= '0;
            q_cnt      <= '0;
            cur_time_q <= '0;
            cur_ev_q   <= '0;
            evcnt_q    <= '0;
            dout_vld_q <= 1'b0;
            dout_dat_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pace_q     <= tick ? '0 : pace_q + PCW'(1);
            byte_cnt_q <= byte_cnt_d;
            dout_vld_q <= emit;
            dout_dat_q <= emit ? emit_dat : 8'h00;
            if (q_push) q_wr <= q_wr + QAW'(1);
            if (q_pop)  q_rd <= q_rd + QAW'(1);
            case ({q_push, q_pop})
                2'b10:   q_cnt <= q_cnt + (QAW+1)'(1);
                2'b01:   q_cnt <= q_cnt - (QAW+1)'(1);
                default: q_cnt <= q_cnt;
            endcase
            if (q_pop) cur_time_q <= q_head;
            if (emit_b0) begin
                cur_ev_q <= evcnt_q;
                evcnt_q  <= evcnt_q + 15'd1;
            end
            if (trig_i && q_full) ovf_q <= 1'b1;
            if (unf_set)          unf_q <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (q_push) q_mem[q_wr] <= trig_time_i;
    end

`ifdef SURF_DOUT_TEST_PATTERN_EN
    assign s_data_tready = 1'b0;
`else
    assign s_data_tready = (state_q == DATA) && tick;
`endif
    assign m_dout_tdata    = dout_dat_q;
    assign m_dout_tvalid   = dout_vld_q;
    assign busy_o          = (state_q != IDLE);
    assign trig_overflow_o = ovf_q;
    assign underflow_o     = unf_q;
endmodule

// File: tb/tb_surf_dout_event_emitter.sv
// Bench for surf_dout_event_emitter: slot-level reference model compared every cycle,
// plus directed header/length/sticky expectations and a randomized trigger/source phase.
module tb_surf_dout_event_emitter;
    localparam int NC = 2, CB = 12, BP = 3, TD = 16;
    localparam int NB = 4 + NC * CB;

    logic        aclk = 1'b0, aresetn = 1'b0, trig_i = 1'b0;
    logic [14:0] trig_time_i = '0;
    logic [7:0]  s_data_tdata = '0;
    logic        s_data_tvalid = 1'b0;
    logic        s_data_tready, m_dout_tvalid, busy_o, trig_overflow_o, underflow_o;
    logic [7:0]  m_dout_tdata;

    surf_dout_event_emitter #(.NUM_CH(NC), .CH_BYTES(CB), .BYTE_PERIOD(BP), .TRIG_DEPTH(TD)) dut (
        .aclk(aclk), .aresetn(aresetn), .trig_i(trig_i), .trig_time_i(trig_time_i),
        .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
        .m_dout_tdata(m_dout_tdata), .m_dout_tvalid(m_dout_tvalid), .busy_o(busy_o),
        .trig_overflow_o(trig_overflow_o), .underflow_o(underflow_o));

    always #5 aclk = ~aclk;

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one event is a list of NB slots; a slot is consumed per pace tick.
    int          m_pos = -1, m_pace = 0;
    bit          m_gap = 0, m_ovf = 0, m_unf = 0, chk_en = 0, m_tick, m_full;
    logic [14:0] m_q[$];
    logic [14:0] m_time, m_evcnt, m_curev;
    bit          e_vld, e_tready, e_busy;
    logic [7:0]  e_dat;

    task automatic model_emit();
        e_vld = 1'b1;
        case (m_pos)
            0: begin
                m_curev = m_evcnt;
                m_evcnt = m_evcnt + 15'd1;
                e_dat   = {1'b1, m_time[14:8]};
            end
            1: e_dat = m_time[7:0];
            2: e_dat = {1'b0, m_curev[14:8]};
            3: e_dat = m_curev[7:0];
            default: begin
`ifdef SURF_DOUT_TEST_PATTERN_EN
                e_dat = 8'(m_pos);
`else
                e_dat = s_data_tvalid ? s_data_tdata : 8'h00;
                if (!s_data_tvalid) m_unf = 1'b1;
`endif
            end
        endcase
        m_pos++;
        if (m_pos == NB) begin
            m_pos = -1;
            m_gap = 1'b1;
        end
    endtask

    always @(posedge aclk) begin
        cyc++;
        if (!aresetn) begin
            m_q.delete();
            m_pos = -1; m_gap = 0; m_pace = 0; m_evcnt = '0; m_curev = '0;
            m_ovf = 0; m_unf = 0; e_vld = 0; e_dat = '0;
            chk_en = 1'b1;
        end else begin
            m_tick = (m_pace == BP - 1);
            m_pace = (m_pace + 1) % BP;
            m_full = (m_q.size() >= TD);
            e_vld  = 1'b0;
            e_dat  = 8'h00;
            if (m_tick) begin
                if (m_pos >= 0) model_emit();
                else if (m_gap) begin
                    m_gap = 1'b0;
                    if (m_q.size() > 0) begin
                        m_time = m_q.pop_front();
                        m_pos  = 0;
                    end
                end else if (m_q.size() > 0) begin
                    m_time = m_q.pop_front();
                    m_pos  = 0;
                    model_emit();
                end
            end
            if (trig_i) begin
                if (m_full) m_ovf = 1'b1;
                else        m_q.push_back(trig_time_i);
            end
        end
        e_busy = (m_pos >= 0) || m_gap;
`ifdef SURF_DOUT_TEST_PATTERN_EN
        e_tready = 1'b0;
`else
        e_tready = (m_pos >= 4) && (m_pace == BP - 1);
`endif
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            check("dout_vld", m_dout_tvalid, e_vld);
            check("dout_dat", m_dout_tdata, e_dat);
            check("tready", s_data_tready, e_tready);
            check("busy", busy_o, e_busy);
            check("ovf", trig_overflow_o, m_ovf);
            check("unf", underflow_o, m_unf);
        end
    end

    // Event segmentation of the DUT output, used by the directed expectations.
    logic [31:0] ev_hdr[$], mon_hdr;
    logic [7:0]  ev_b20[$], mon_b20;
    int          ev_start[$], ev_end[$], mon_idx = 0, mon_start = 0;

    always @(negedge aclk) begin
        if (aresetn && m_dout_tvalid === 1'b1) begin
            if (mon_idx == 0) mon_start = cyc;
            if (mon_idx < 4)  mon_hdr = {mon_hdr[23:0], m_dout_tdata};
            if (mon_idx == 20) mon_b20 = m_dout_tdata;
            mon_idx++;
            if (mon_idx == NB) begin
                ev_hdr.push_back(mon_hdr);
                ev_b20.push_back(mon_b20);
                ev_start.push_back(mon_start);
                ev_end.push_back(cyc);
                mon_idx = 0;
            end
        end
    end

    function automatic logic [31:0] hdr_at(input int i);
        return (ev_hdr.size() > i) ? ev_hdr[i] : 32'hDEAD_BEEF;
    endfunction

    // Source: fresh random byte every cycle; valid can be forced low at one byte index.
    int drop_pos = -1;
    bit src_rand = 0;
    initial begin
        forever begin
            @(negedge aclk);
            s_data_tdata  = 8'($urandom);
            s_data_tvalid = (m_pos != drop_pos) && (!src_rand || $urandom_range(0, 7) != 0);
        end
    end

    task automatic clear_mon();
        ev_hdr.delete(); ev_b20.delete(); ev_start.delete(); ev_end.delete();
        mon_idx = 0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        trig_i  = 1'b0;
        repeat (2) @(negedge aclk);
        clear_mon();
        aresetn = 1'b1;
    endtask

    task automatic trig_burst(input int n, input logic [14:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            trig_i      = 1'b1;
            trig_time_i = base + 15'(i);
        end
        @(negedge aclk);
        trig_i = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((m_pos >= 0 || m_gap || m_q.size() > 0) && n < max) begin
            @(negedge aclk);
            n++;
        end
        if (n >= max) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
        @(negedge aclk);
    endtask

    initial begin
        int n, drops;
        bit seen;

        do_reset();
        check("rst_vld", m_dout_tvalid, 0);
        check("rst_dat", m_dout_tdata, 0);
        check("rst_tready", s_data_tready, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", trig_overflow_o, 0);
        check("rst_unf", underflow_o, 0);

        // Single event, header and beat spacing.
        trig_burst(1, 15'h1234);
        wait_idle(1000);
        check("t1_events", ev_hdr.size(), 1);
        check("t1_hdr", hdr_at(0), 32'h9234_0000);
        if (ev_end.size() > 0) check("t1_span", ev_end[0] - ev_start[0], (NB - 1) * BP);

        // Three back-to-back triggers.
        do_reset();
        trig_burst(3, 15'h0100);
        n = 0; drops = 0; seen = 0;
        while (ev_hdr.size() < 3 && n < 2000) begin
            @(negedge aclk);
            if (busy_o) seen = 1;
            else if (seen) drops++;
            n++;
        end
        check("t2_busy_drops", drops, 0);
        wait_idle(1000);
        check("t2_events", ev_hdr.size(), 3);
        for (int i = 0; i < 3; i++) check("t2_hdr", hdr_at(i), 32'h8100_0000 + (i << 16) + i);
        if (ev_start.size() > 2) begin
            check("t2_gap01", (ev_start[1] - ev_end[0]) >= 2 * BP, 1);
            check("t2_gap12", (ev_start[2] - ev_end[1]) >= 2 * BP, 1);
        end
        check("t2_busy_end", busy_o, 0);

        // Queue overflow during a long event.
        do_reset();
        trig_burst(1, 15'h000A);
        n = 0;
        while (m_pos < 1 && n < 100) begin @(negedge aclk); n++; end
        trig_burst(17, 15'h0200);
        wait_idle(4000);
        check("t3_ovf", trig_overflow_o, 1);
        check("t3_events", ev_hdr.size(), 17);
        check("t3_last_hdr", hdr_at(16), 32'h820F_0010);

        // Source underflow at data byte 20.
        do_reset();
        drop_pos = 20;
        trig_burst(1, 15'h7FFF);
        wait_idle(1000);
        drop_pos = -1;
        check("t4_events", ev_hdr.size(), 1);
        check("t4_hdr", hdr_at(0), 32'hFFFF_0000);
`ifdef SURF_DOUT_TEST_PATTERN_EN
        check("t4_unf", underflow_o, 0);
        if (ev_b20.size() > 0) check("t4_b20", ev_b20[0], 8'd20);
`else
        check("t4_unf", underflow_o, 1);
        if (ev_b20.size() > 0) check("t4_b20", ev_b20[0], 8'h00);
`endif

        // Reset in the middle of an event with stickies set and a full queue.
        do_reset();
        drop_pos = 6;
        trig_burst(20, 15'h0300);
        n = 0;
        while (m_pos != 20 && n < 200) begin @(negedge aclk); n++; end
        drop_pos = -1;
        check("t5_ovf_before", trig_overflow_o, 1);
        aresetn = 1'b0;
        @(negedge aclk);
        check("t5_vld_after_rst", m_dout_tvalid, 0);
        check("t5_ovf_cleared", trig_overflow_o, 0);
        check("t5_unf_cleared", underflow_o, 0);
        aresetn = 1'b1;
        clear_mon();
        repeat (12) @(negedge aclk);
        check("t5_queue_empty", busy_o, 0);
        trig_burst(1, 15'h0055);
        wait_idle(1000);
        check("t5_hdr", hdr_at(0), 32'h8055_0000);

        // Random triggers and a flaky source.
        do_reset();
        src_rand = 1;
        for (int i = 0; i < 600; i++) begin
            @(negedge aclk);
            trig_i      = ($urandom_range(0, 29) == 0);
            trig_time_i = 15'($urandom);
        end
        @(negedge aclk);
        trig_i = 1'b0;
        wait_idle(4000);
        src_rand = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
